// File: rtl/spi_frame_controller.sv
// spi_frame_controller
//   Sequences SPI traffic for the OCR datapath. It decodes command bytes from the
//   SPI peripheral and streams packed pixel bytes into the image buffer. It then
//   launches BNN inference and latches the class result. It also builds the status
//   byte {ready, busy, error, 0, result[3:0]} that the peripheral shifts out.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   rx_byte, byte_valid       received byte and its 1-cycle strobe
//   cs_n                      chip-select (synchronised); high ends the frame
//   img_we/img_addr/img_wdata image buffer write port (1 cycle after byte_valid)
//   infer_start               1-cycle pulse to the BNN core
//   infer_done, infer_result  completion pulse and class index from the BNN core
//   tx_byte, tx_load          status byte and its load strobe for the SPI TX path
//   busy                      high while a frame is loading or being classified
module spi_frame_controller #(
  parameter int unsigned IMG_BYTES   = 113,
  parameter int unsigned TIMEOUT_CYC = 100000,
  localparam int unsigned AW         = $clog2(IMG_BYTES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_byte,
  input  logic          byte_valid,
  input  logic          cs_n,
  output logic          img_we,
  output logic [AW-1:0] img_addr,
  output logic [7:0]    img_wdata,
  output logic          infer_start,
  input  logic          infer_done,
  input  logic [3:0]    infer_result,
  output logic [7:0]    tx_byte,
  output logic          tx_load,
  output logic          busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_BYTES - 1);
  localparam logic [TW-1:0] TIMEOUT   = TW'(TIMEOUT_CYC);

  localparam logic [7:0] CMD_LOAD   = 8'hA1;
  localparam logic [7:0] CMD_STATUS = 8'hC3;
  localparam logic [7:0] CMD_CLEAR  = 8'hFF;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, WAIT_DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] addr, addr_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          ready, ready_nxt;
  logic          error, error_nxt;
  logic [3:0]    result, result_nxt;
  logic          we_nxt, start_nxt, status_req;

  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr;
    timer_nxt  = timer;
    ready_nxt  = ready;
    error_nxt  = error;
    result_nxt = result;
    we_nxt     = 1'b0;
    start_nxt  = 1'b0;
    // Inside LOAD every byte is pixel data, so a 0xC3 there must not answer.
    status_req = byte_valid && (rx_byte == CMD_STATUS) && (state != LOAD);

    unique case (state)
      IDLE: begin
        if (byte_valid) begin
          unique case (rx_byte)
            CMD_LOAD: begin
              state_nxt = LOAD;
              addr_nxt  = '0;
              timer_nxt = '0;
              ready_nxt = 1'b0;
              error_nxt = 1'b0;
            end
            CMD_CLEAR: begin
              ready_nxt  = 1'b0;
              error_nxt  = 1'b0;
              result_nxt = '0;
            end
            CMD_STATUS: ;
            default: error_nxt = 1'b1;
          endcase
        end
      end
      LOAD: begin
        if (byte_valid) begin
          we_nxt    = 1'b1;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + 1'b1;
        end
        // A byte that completes the frame wins over a simultaneous cs_n rise.
        if (byte_valid && addr == LAST_ADDR) begin
          state_nxt = RUN;
        end else if (cs_n || (!byte_valid && timer == TIMEOUT)) begin
          state_nxt = IDLE;
          error_nxt = 1'b1;
        end else if (byte_valid) begin
          addr_nxt = addr + 1'b1;
        end
      end
      RUN: begin
        start_nxt = 1'b1;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (infer_done) begin
          result_nxt = infer_result;
          ready_nxt  = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      addr        <= '0;
      timer       <= '0;
      ready       <= 1'b0;
      error       <= 1'b0;
      result      <= '0;
      img_we      <= 1'b0;
      img_addr    <= '0;
      img_wdata   <= '0;
      infer_start <= 1'b0;
      tx_byte     <= '0;
      tx_load     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      addr        <= addr_nxt;
      timer       <= timer_nxt;
      ready       <= ready_nxt;
      error       <= error_nxt;
      result      <= result_nxt;
      img_we      <= we_nxt;
      infer_start <= start_nxt;
      tx_load     <= status_req;
      busy        <= (state_nxt != IDLE);
      if (we_nxt) begin
        img_addr  <= addr;
        img_wdata <= rx_byte;
      end
      // Built from next-state values so a STATUS that coincides with
      // infer_done reports the freshly latched result.
      if (status_req)
        tx_byte <= {ready_nxt, (state_nxt != IDLE), error_nxt, 1'b0, result_nxt};
    end
  end

endmodule

// File: tb/tb_spi_frame_controller.sv
module tb_spi_frame_controller;

  localparam int unsigned IMG  = 113;
  localparam int unsigned TOUT = 200;
  localparam int unsigned AW   = $clog2(IMG);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    rx_byte = '0;
  logic          byte_valid = 1'b0;
  logic          cs_n = 1'b1;
  logic          img_we;
  logic [AW-1:0] img_addr;
  logic [7:0]    img_wdata;
  logic          infer_start;
  logic          infer_done = 1'b0;
  logic [3:0]    infer_result = '0;
  logic [7:0]    tx_byte;
  logic          tx_load;
  logic          busy;

  spi_frame_controller #(.IMG_BYTES(IMG), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .byte_valid(byte_valid), .cs_n(cs_n),
    .img_we(img_we), .img_addr(img_addr), .img_wdata(img_wdata),
    .infer_start(infer_start), .infer_done(infer_done), .infer_result(infer_result),
    .tx_byte(tx_byte), .tx_load(tx_load), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Monitor of the image write port and inference launches.
  int cyc = 0;
  int got_addr[$];
  int got_data[$];
  int starts = 0;
  int last_we_cyc = 0;
  int start_cyc = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (img_we) begin
      got_addr.push_back(int'(img_addr));
      got_data.push_back(int'(img_wdata));
      last_we_cyc = cyc;
    end
    if (infer_start) begin
      starts++;
      start_cyc = cyc;
    end
  end

  // Reference model: controller-visible state kept as plain flags.
  bit       m_ready = 0;
  bit       m_error = 0;
  bit [3:0] m_result = '0;
  int       exp_data[$];

  function automatic int status_of(input bit b);
    return {m_ready, b, m_error, 1'b0, m_result};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit cs_high);
    @(posedge clk); #1;
    rx_byte = b; byte_valid = 1'b1;
    if (cs_high) cs_n = 1'b1;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    if (cs_high) cs_n = 1'b0;
  endtask

  task automatic status(input string tag, input bit exp_busy);
    send_byte(8'hC3, 1'b0);
    @(negedge clk);
    check({tag, "_txload"}, int'(tx_load), 1);
    check({tag, "_txbyte"}, int'(tx_byte), status_of(exp_busy));
    @(negedge clk);
    check({tag, "_txload_pulse"}, int'(tx_load), 0);
  endtask

  // Sends LOAD plus n pixel bytes with random gaps; the last byte optionally
  // carries a cs_n rise.
  task automatic load_frame(input int n, input bit rnd, input bit cs_last);
    got_addr.delete(); got_data.delete(); exp_data.delete();
    cs_n = 1'b0;
    send_byte(8'hA1, 1'b0);
    m_ready = 0; m_error = 0;
    for (int i = 0; i < n; i++) begin
      logic [7:0] d;
      d = rnd ? 8'($urandom) : 8'(i % 256);
      exp_data.push_back(int'(d));
      send_byte(d, cs_last && (i == n - 1));
      idle($urandom_range(0, 3));
    end
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_wr_count"}, got_addr.size(), exp_data.size());
    for (int i = 0; i < got_addr.size() && i < exp_data.size(); i++) begin
      check({tag, "_wr_addr"}, got_addr[i], i);
      check({tag, "_wr_data"}, got_data[i], exp_data[i]);
    end
  endtask

  task automatic full_frame(input string tag, input bit rnd, input bit cs_last);
    int s0;
    logic [3:0] r;
    s0 = starts;
    load_frame(IMG, rnd, cs_last);
    idle(4);
    check_writes(tag);
    check({tag, "_one_start"}, starts - s0, 1);
    check({tag, "_start_lat"}, start_cyc - last_we_cyc, 1);
    check({tag, "_busy_wait"}, int'(busy), 1);
    status({tag, "_st_wait"}, 1'b1);
    // Non-status byte while waiting is dropped silently.
    send_byte(8'h55, 1'b0);
    idle(2);
    check({tag, "_drop_nowrite"}, got_addr.size(), IMG);
    status({tag, "_st_drop"}, 1'b1);
    r = 4'($urandom);
    if (rnd) begin
      // infer_done and STATUS in the same cycle: post-update value reported.
      @(posedge clk); #1;
      infer_done = 1'b1; infer_result = r; rx_byte = 8'hC3; byte_valid = 1'b1;
      @(posedge clk); #1;
      infer_done = 1'b0; byte_valid = 1'b0;
      m_ready = 1; m_result = r;
      @(negedge clk);
      check({tag, "_st_same_load"}, int'(tx_load), 1);
      check({tag, "_st_same_byte"}, int'(tx_byte), status_of(1'b0));
    end else begin
      r = 4'd7;
      @(posedge clk); #1;
      infer_done = 1'b1; infer_result = r;
      @(posedge clk); #1;
      infer_done = 1'b0;
      m_ready = 1; m_result = r;
      status({tag, "_st_done"}, 1'b0);
      check({tag, "_st_done_0x87"}, int'(tx_byte), 8'h87);
    end
    check({tag, "_busy_done"}, int'(busy), 0);
  endtask

  initial begin
    int s0, n;
    logic [7:0] bad;

    idle(3);
    check("rst_busy", int'(busy), 0);
    check("rst_we", int'(img_we), 0);
    check("rst_start", int'(infer_start), 0);
    check("rst_txload", int'(tx_load), 0);
    check("rst_txbyte", int'(tx_byte), 0);
    rst = 1'b1; cs_n = 1'b0;
    idle(2);
    status("t1", 1'b0);

    full_frame("t2", 1'b0, 1'b0);
    full_frame("t2r", 1'b1, 1'b0);
    full_frame("t2cs", 1'b1, 1'b1);

    // Early cs_n rise aborts the frame.
    s0 = starts;
    n = $urandom_range(1, IMG - 2);
    load_frame(n, 1'b1, 1'b0);
    @(posedge clk); #1; cs_n = 1'b1;
    @(posedge clk); #1; cs_n = 1'b0;
    m_error = 1;
    idle(3);
    check("t3_busy", int'(busy), 0);
    check("t3_nostart", starts - s0, 0);
    check_writes("t3");
    status("t3_st", 1'b0);

    // Inactivity timeout, then CLEAR.
    s0 = starts;
    load_frame(10, 1'b1, 1'b0);
    idle(TOUT - 5);
    check("t4_busy_before", int'(busy), 1);
    idle(10);
    m_error = 1;
    check("t4_busy_after", int'(busy), 0);
    check("t4_nostart", starts - s0, 0);
    status("t4_st", 1'b0);
    send_byte(8'hFF, 1'b0);
    m_ready = 0; m_error = 0; m_result = '0;
    status("t4_clr", 1'b0);

    // Stray infer_done in IDLE, then random bad commands.
    full_frame("t6f", 1'b1, 1'b0);
    @(posedge clk); #1; infer_done = 1'b1; infer_result = ~m_result;
    @(posedge clk); #1; infer_done = 1'b0;
    status("t6_stray", 1'b0);
    for (int k = 0; k < 4; k++) begin
      bad = 8'($urandom);
      while (bad == 8'hA1 || bad == 8'hC3 || bad == 8'hFF) bad = 8'($urandom);
      if (k == 0) bad = 8'h12;
      send_byte(bad, 1'b0);
      m_error = 1;
      status("t6_bad", 1'b0);
    end

    // Asynchronous reset mid-LOAD: no launch, everything cleared.
    s0 = starts;
    load_frame(IMG - 1, 1'b1, 1'b0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_txbyte", int'(tx_byte), 0);
    idle(2);
    rst = 1'b1;
    m_ready = 0; m_error = 0; m_result = '0;
    send_byte(8'h3C, 1'b0);
    idle(3);
    check("arst_nostart", starts - s0, 0);
    check("arst_nowrite", got_addr.size(), IMG - 1);
    m_error = 1;
    status("arst_st", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
